// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port, byte-enabled, synchronous-read RAM.
// Fixed priority with an m1 starvation guard by default; define RAM_ARBITER_ROUND_ROBIN_EN for round robin.
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        ram_req,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    logic owner_valid_q;
    logic owner_id_q;
    logic m1_win;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic rr_q, rr_d;

    always_comb begin
        rr_d   = rr_q;
        m1_win = m1_req && (!m0_req || rr_q);
        // pointer moves to the loser of every granted access
        if (m0_req || m1_req) begin
            rr_d = !m1_win;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    logic [7:0] starve_q, starve_d;

    always_comb begin
        starve_d = '0;
        m1_win   = m1_req && (!m0_req || starve_q == LIMIT);
        if (m1_req && !m1_win) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    assign m1_gnt    = m1_win;
    assign m0_gnt    = m0_req && !m1_win;
    assign ram_req   = m0_gnt || m1_gnt;
    assign ram_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign ram_we    = m1_gnt ? m1_we    : m0_we;
    assign ram_be    = m1_gnt ? m1_be    : m0_be;
    assign ram_wdata = m1_gnt ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_valid_q <= 1'b0;
            owner_id_q    <= 1'b0;
        end else begin
            owner_valid_q <= ram_req;
            owner_id_q    <= m1_gnt;
        end
    end

    assign m0_rvalid = owner_valid_q && !owner_id_q;
    assign m1_rvalid = owner_valid_q && owner_id_q;
    assign m0_rdata  = ram_rdata;
    assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter: RAM model, reference memory and grant model.
// Honours RAM_ARBITER_ROUND_ROBIN_EN to select the expected arbitration policy.
module tb_ram_arbiter;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_rvalid, m0_we;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_gnt, m1_rvalid, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_be;

    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];

    int tests = 0;
    int fails = 0;

    // reference model state
    int          cnt_m;
    bit          ptr_m;
    bit          ev, eid, erd;
    logic [31:0] edata;
    bit          last_g0, last_g1;

    ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_addr(m0_addr),
        .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_addr(m1_addr),
        .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .ram_req(ram_req), .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM macro: byte-enabled write, registered read
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr[9:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cnt_m = 0; ptr_m = 1'b0; ev = 1'b0; eid = 1'b0; erd = 1'b0;
        last_g0 = 1'b0; last_g1 = 1'b0;
    endtask

    // Called at a negedge with inputs already applied; checks, advances model, returns at next negedge.
    task automatic cycle();
        bit          g0, g1;
        logic [31:0] a, wd;
        logic        we;
        logic [3:0]  be;
        int          idx;
        #1;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        g1 = m1_req && (!m0_req || ptr_m);
`else
        g1 = m1_req && (!m0_req || cnt_m >= LIMIT);
`endif
        g0 = m0_req && !g1;
        a  = g1 ? m1_addr  : m0_addr;
        we = g1 ? m1_we    : m0_we;
        be = g1 ? m1_be    : m0_be;
        wd = g1 ? m1_wdata : m0_wdata;
        chk("m0_gnt", m0_gnt, g0);
        chk("m1_gnt", m1_gnt, g1);
        chk("ram_req", ram_req, g0 | g1);
        chk("ram_addr", ram_addr, a);
        chk("ram_we", ram_we, we);
        chk("ram_be", ram_be, be);
        chk("ram_wdata", ram_wdata, wd);
        chk("m0_rvalid", m0_rvalid, ev && !eid);
        chk("m1_rvalid", m1_rvalid, ev && eid);
        if (ev && erd) chk("rdata", eid ? m1_rdata : m0_rdata, edata);

        ev  = g0 | g1;
        eid = g1;
        erd = ev && !we;
        idx = int'(a[9:2]);
        if (erd) edata = ref_mem[idx];
        if (ev && we)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        if (m1_req && !g1) cnt_m = (cnt_m < LIMIT) ? cnt_m + 1 : cnt_m;
        else               cnt_m = 0;
        if (ev) ptr_m = !g1;
        last_g0 = g0;
        last_g1 = g1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_m0();
        m0_we    = $urandom_range(0, 1) == 1;
        m0_be    = 4'($urandom_range(0, 15));
        m0_wdata = $urandom();
        m0_addr  = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
    endtask

    task automatic rand_m1();
        m1_we    = $urandom_range(0, 1) == 1;
        m1_be    = 4'($urandom_range(0, 15));
        m1_wdata = $urandom();
        m1_addr  = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
    endtask

    task automatic idle();
        m0_req = 1'b0; m1_req = 1'b0;
        m0_we = 1'b0; m1_we = 1'b0;
        m0_be = 4'hF; m1_be = 4'hF;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    endtask

    // Both masters request continuously; grant pattern pinned by literals.
    task automatic contention(input string tag);
        bit exp1;
        m0_req = 1'b1; m1_req = 1'b1;
        rand_m0(); rand_m1();
        for (int k = 0; k < 12; k++) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
            exp1 = (k % 2) == 1;
`else
            exp1 = (k % 4) == 3;
`endif
            #1;
            chk({tag, "_m1_gnt"}, m1_gnt, exp1);
            chk({tag, "_m0_gnt"}, m0_gnt, !exp1);
            #1;
            cycle();
            chk({tag, "_m1_rvalid"}, m1_rvalid, exp1);
            if (last_g0) rand_m0();
            if (last_g1) rand_m1();
        end
        idle();
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = $urandom();
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
        ram_mem[8'h20] = 32'h11223344; ref_mem[8'h20] = 32'h11223344;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m0_rvalid", m0_rvalid, 1'b0);
        chk("rst_m1_rvalid", m1_rvalid, 1'b0);
        chk("rst_ram_req", ram_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // single master read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        cycle();
        idle();
        chk("single_m0_rvalid", m0_rvalid, 1'b1);
        chk("single_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("single_m1_rvalid", m1_rvalid, 1'b0);
        cycle();

        // m1 byte write then read
        m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0010; m1_wdata = 32'h0000AB00; m1_addr = 32'h80;
        cycle();
        m1_we = 1'b0; m1_be = 4'hF;
        cycle();
        idle();
        chk("bytewr_m1_rvalid", m1_rvalid, 1'b1);
        chk("bytewr_m1_rdata", m1_rdata, 32'h1122AB44);
        cycle();

        contention("cont");

        // back-to-back m0 reads
        for (int i = 0; i < 8; i++) begin
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'(i * 4);
            #1;
            chk("b2b_gnt", m0_gnt, 1'b1);
            if (i > 0) chk("b2b_rvalid", m0_rvalid, 1'b1);
            #1;
            cycle();
        end
        idle();
        chk("b2b_last_rvalid", m0_rvalid, 1'b1);
        chk("b2b_last_rdata", m0_rdata, ref_mem[7]);
        cycle();

        // build up m1 starvation, then reset while an m0 read is in flight
        m0_req = 1'b1; m1_req = 1'b1; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h4;
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        idle();
        chk("midrst_m0_rvalid", m0_rvalid, 1'b0);
        chk("midrst_m1_rvalid", m1_rvalid, 1'b0);
        @(posedge clk);
        #1;
        chk("inrst_m0_rvalid", m0_rvalid, 1'b0);
        chk("inrst_m1_rvalid", m1_rvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        chk("postrst_ram_req", ram_req, 1'b0);
        chk("postrst_m0_rvalid", m0_rvalid, 1'b0);
        #1;
        cycle();
        contention("postrst");

        // randomized traffic; masters hold requests until granted
        for (int n = 0; n < 3000; n++) begin
            if (!m0_req || last_g0) begin
                m0_req = $urandom_range(0, 3) != 0;
                rand_m0();
            end
            if (!m1_req || last_g1) begin
                m1_req = $urandom_range(0, 3) != 0;
                rand_m1();
            end
            cycle();
        end
        idle();
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
